// File: rtl/mem_pkg.sv
// Shared definitions for the byte-banked instruction memory: address limit,
// read-side clamp address, writer FSM states and big-endian lane extraction.
package mem_pkg;

  localparam int unsigned MEM_LIMIT     = 393216;
  localparam logic [18:0] RD_CLAMP_ADDR = 19'h5FFFC;

  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_e;

  // Lane 0 is the most significant byte (stored at the lowest address).
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    return word[31-8*idx -: 8];
  endfunction

endpackage

// File: rtl/imem_word_writer.sv
// Serialises 32-bit word writes into four big-endian byte writes on a
// byte-wide RAM port, suppressing and flagging bytes beyond the memory limit.
module imem_word_writer #(
  parameter int          ADDR_W    = 19,
  parameter int unsigned MEM_LIMIT = mem_pkg::MEM_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [3:0]        req_be,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_oob
);
  import mem_pkg::*;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          be_q, be_d;
  logic                oob_q, oob_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic [1:0]          sel_idx;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_data;
  logic [3:0]          sel_be;
  logic [32:0]         sum;
  logic                in_range;
  logic                lane_en;

  // Byte about to be presented: lane 0 of the incoming request when idle,
  // otherwise the next lane of the latched word. The sum is 33 bits so an
  // address near 2^32 cannot wrap back into range.
  always_comb begin
    sel_idx  = 2'd0;
    sel_addr = req_addr;
    sel_data = req_data;
    sel_be   = req_be;
    if (state_q == WR) begin
      sel_idx  = 2'(idx_q + 2'd1);
      sel_addr = addr_q;
      sel_data = data_q;
      sel_be   = be_q;
    end
    sum      = {1'b0, sel_addr} + {31'd0, sel_idx};
    in_range = sum < 33'(MEM_LIMIT);
    lane_en  = sel_be[~sel_idx];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    oob_d   = oob_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = WR;
          idx_d   = 2'd0;
          addr_d  = req_addr;
          data_d  = req_data;
          be_d    = req_be;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          we_d    = lane_en && in_range;
          maddr_d = sum[ADDR_W-1:0];
          wdata_d = byte_lane(sel_data, sel_idx);
          oob_d   = lane_en && !in_range;
        end
      end
      WR: begin
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = oob_q;
        end else begin
          idx_d   = sel_idx;
          we_d    = lane_en && in_range;
          maddr_d = sum[ADDR_W-1:0];
          wdata_d = byte_lane(sel_data, sel_idx);
          oob_d   = oob_q | (lane_en && !in_range);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      oob_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oob_q   <= oob_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Latched request fields carry no control meaning and need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_oob   = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_word_writer.sv
// Directed, table-driven bench for imem_word_writer plus hand-written
// back-to-back and mid-request reset sequences.
module tb_imem_word_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  imem_word_writer #(.ADDR_W(19), .MEM_LIMIT(393216)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_be    (req_be),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err_oob   (err_oob)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       be;
    logic [0:3]       we;
    logic [0:3][18:0] maddr;
    logic [0:3][7:0]  wdata;
    logic             err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
  endtask

  // Called on a negedge; leaves the bench on the negedge of the done cycle.
  task automatic run_vec(input int k);
    string nm;
    nm = $sformatf("v%0d", k);
    wait_ready(nm);
    req_addr  = vecs[k].addr;
    req_data  = vecs[k].data;
    req_be    = vecs[k].be;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~vecs[k].addr;
    req_data  = ~vecs[k].data;
    req_be    = ~vecs[k].be;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_b%0d_we", nm, i), 64'(mem_we), 64'(vecs[k].we[i]));
      check($sformatf("%s_b%0d_addr", nm, i), 64'(mem_addr), 64'(vecs[k].maddr[i]));
      check($sformatf("%s_b%0d_wdata", nm, i), 64'(mem_wdata), 64'(vecs[k].wdata[i]));
      check($sformatf("%s_b%0d_busy_done_rdy", nm, i), {61'd0, busy, done, req_ready}, 64'b100);
      @(negedge clk);
    end
    check({nm, "_done"}, 64'(done), 64'd1);
    check({nm, "_err"}, 64'(err_oob), 64'(vecs[k].err));
    check({nm, "_end_busy_we_rdy"}, {61'd0, busy, mem_we, req_ready}, 64'b001);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hDEADBEEF, 4'hF, 4'b1111,
                {19'h00100, 19'h00101, 19'h00102, 19'h00103},
                {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'h11223344, 4'b0101, 4'b0101,
                {19'h00200, 19'h00201, 19'h00202, 19'h00203},
                {8'h11, 8'h22, 8'h33, 8'h44}, 1'b0};
    vecs[2] = '{32'd393214, 32'hA1B2C3D4, 4'hF, 4'b1100,
                {19'h5FFFE, 19'h5FFFF, 19'h60000, 19'h60001},
                {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h55667788, 4'hF, 4'b0000,
                {19'h00000, 19'h00001, 19'h00002, 19'h00003},
                {8'h55, 8'h66, 8'h77, 8'h88}, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h12345678, 4'h0, 4'b0000,
                {19'h00000, 19'h00001, 19'h00002, 19'h00003},
                {8'h12, 8'h34, 8'h56, 8'h78}, 1'b0};
    vecs[5] = '{32'h0000_0003, 32'hCAFEF00D, 4'b1010, 4'b1010,
                {19'h00003, 19'h00004, 19'h00005, 19'h00006},
                {8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0};
    vecs[6] = '{32'd393215, 32'h01020304, 4'b0111, 4'b0000,
                {19'h5FFFF, 19'h60000, 19'h60001, 19'h60002},
                {8'h01, 8'h02, 8'h03, 8'h04}, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0A0B0C0D, 4'hF, 4'b0000,
                {19'h7FFFF, 19'h00000, 19'h00001, 19'h00002},
                {8'h0A, 8'h0B, 8'h0C, 8'h0D}, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h100;
    req_data  = 32'hFFFF_FFFF;
    req_be    = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_we, busy, done, err_oob, req_ready, 8'(mem_wdata), 19'(mem_addr)}, 64'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {61'd0, req_ready, busy, mem_we}, 64'b100);

    for (int k = 0; k < 8; k++) run_vec(k);

    // Back-to-back: second request held on req_valid, taken in the done cycle.
    @(negedge clk);
    req_addr  = 32'h400;
    req_data  = 32'hA0A1A2A3;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h500;
    req_data = 32'hB0B1B2B3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_a_b%0d_addr_we", i), {44'd0, mem_we, 19'(mem_addr)}, {44'd0, 1'b1, 19'h400 + 19'(i)});
      @(negedge clk);
    end
    check("b2b_a_done_ready", {62'd0, done, req_ready}, 64'b11);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_b_first", {36'd0, mem_we, 19'(mem_addr), mem_wdata}, {36'd0, 1'b1, 19'h500, 8'hB0});
    repeat (3) @(negedge clk);
    check("b2b_b_last", {36'd0, mem_we, 19'(mem_addr), mem_wdata}, {36'd0, 1'b1, 19'h503, 8'hB3});
    @(negedge clk);
    check("b2b_b_done", 64'(done), 64'd1);

    // Reset after the second byte: the remaining bytes and done must vanish.
    @(negedge clk);
    req_addr  = 32'h300;
    req_data  = 32'h01020304;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_b0", {44'd0, mem_we, 19'(mem_addr)}, {44'd0, 1'b1, 19'h300});
    @(negedge clk);
    check("rst_b1", {44'd0, mem_we, 19'(mem_addr)}, {44'd0, 1'b1, 19'h301});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), {59'd0, mem_we, busy, done, err_oob, req_ready}, 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d", i), {60'd0, mem_we, busy, done, req_ready}, 64'b0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
